soc_system_debounced_pio: RTL and testbench
===========================================

// Module: soc_system_debounced_pio
// PURPOSE
// - Parametrised Avalon-MM input PIO for the HPS/FPGA bridge. It replaces the fixed 4-bit pushbutton PIO.
// - Each channel passes through a synchroniser and then a counter debouncer.
// - Edge detection is programmable per channel (rise, fall or both), with masked, registered IRQ.
// - Sits between board switches/KEYs and the lightweight bridge; the IRQ goes to the GIC.
// PARAMETERS
// - WIDTH        4      number of input channels (1..32)
// - DEBOUNCE     50000  input must differ from the stable value this many consecutive clocks before the stable value flips (>=1)
// - SYNC_STAGES  2      synchroniser depth (>=2)
// - INIT_LEVEL   1      reset value of sync flops and stable state, replicated to all bits (KEYs idle high)
// PORTS
// - clk        in   1      system clock
// - reset_n    in   1      asynchronous active-low reset
// - address    in   3      word address
// - chipselect in   1      slave select
// - write_n    in   1      active-low write strobe
// - writedata  in   32     write data
// - readdata   out  32     registered read data
// - in_port    in   WIDTH  raw asynchronous inputs
// - irq        out  1      level interrupt, registered
// BEHAVIOUR
// - One clock domain; clk and reset_n only.
// - All registers reset asynchronously on reset_n low:
//   - readdata=0, irq=0, irq_mask=0, edge_capture=0, rise_en=all 1s, fall_en=0.
//   - sync flops and stable state = {WIDTH{INIT_LEVEL}}; counters = 0.
// - Register map (read/write; unused bits read 0):
//   - 0 DATA: debounced stable state (RO)
//   - 1 RAW: last sync stage (RO)
//   - 2 IRQ_MASK: RW
//   - 3 EDGE_CAPTURE: write-1-to-clear
//   - 4 RISE_EN: RW
//   - 5 FALL_EN: RW
//   - 6 PENDING = edge_capture & irq_mask (RO)
//   - 7: reads 0
// - Read latency is 1 clock. readdata is updated every clock from the address-selected mux, no wait states.
// - Writes take effect on the clock when chipselect && !write_n. Writes to RO addresses are ignored.
// - Debounce, per channel:
//   - sync == stable: counter is held at 0.
//   - sync != stable: counter increments.
//   - counter == DEBOUNCE-1 while still differing: stable <= sync, counter <= 0 in the same clock.
//   - Any single-cycle return to the stable value clears the counter.
//   - Latency from a clean input step to DATA change = SYNC_STAGES + DEBOUNCE clocks. Add 1 more to observe it on readdata.
// - Counter width is $clog2(DEBOUNCE+1). The counter never wraps.
// - Edge event, per bit: (stable rises & rise_en) | (stable falls & fall_en). It is a 1-clock pulse, the clock after stable updates.
// - edge_capture sets on an event and clears on a write-1 at address 3.
//   - Same-clock set and clear on one bit: set wins, so no event is lost.
// - irq <= |(edge_capture & irq_mask) is registered. irq asserts 1 clock after capture and deasserts 1 clock after clear or mask.
// - Changing RISE_EN/FALL_EN does not alter already-captured bits.
// - reset_n asserted mid-debounce: counters are lost and no edge is generated at reset release.
// STRUCTURE
// - Package soc_system_pio_pkg holds:
//   - address constants ADDR_DATA..ADDR_PENDING
//   - localparam function for counter width
// - Sub-module soc_system_pio_debounce:
//   - one channel: synchroniser + counter + stable flop + rise/fall pulses
//   - instantiated WIDTH times via generate
// - The top level holds the register file, capture logic, read mux and irq flop.
// TESTING (bench uses WIDTH=4, DEBOUNCE=4, SYNC_STAGES=2, INIT_LEVEL=1)
// - Reset and read back:
//   - reset -> DATA=0xF, RISE_EN=0xF, FALL_EN=0, IRQ_MASK=0, irq=0
//   - after writing IRQ_MASK=0x5, a read of address 2 returns 0x5 one clock later
// - Drive in_port[0] 1->0 and hold 10 clocks with FALL_EN=0x1, MASK=0x1:
//   - DATA[0]=0 exactly 6 clocks after the step
//   - EDGE_CAPTURE=0x1 the next clock
//   - irq=1 one clock after that
// - Bounce rejection: toggle in_port[1] 0,1,0 with 3-clock pulses -> DATA and EDGE_CAPTURE unchanged, irq stays 0.
// - Rise-only filter: FALL_EN=0, RISE_EN=0x2, in_port[1] 1->0->1 held 10 clocks each -> only the 0->1 sets EDGE_CAPTURE[1].
// - W1C collision:
//   - write 0x1 to address 3 on the same clock a new edge event on bit0 fires -> bit0 stays 1
//   - a later write of 0x1 clears it and irq drops 1 clock after
// - Reset mid-debounce: assert reset_n 2 clocks into a step on bit2 -> after release, DATA=0xF, EDGE_CAPTURE=0, no irq.

Source files
------------

// File: rtl/soc_system_pio_pkg.sv
// Shared register map and sizing helpers for the debounced input PIO.
package soc_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_RAW          = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN      = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN      = 3'd5;
  localparam logic [2:0] ADDR_PENDING      = 3'd6;

  // Counter must hold DEBOUNCE-1 without wrapping.
  function automatic int cnt_width(input int debounce);
    return $clog2(debounce + 1);
  endfunction

endpackage

// File: rtl/soc_system_pio_debounce.sv
// One input channel: synchroniser, consecutive-sample debounce counter,
// stable-state flop and registered single-cycle rise/fall pulses.
module soc_system_pio_debounce
  import soc_system_pio_pkg::*;
#(
  parameter int DEBOUNCE    = 50000,
  parameter int SYNC_STAGES = 2,
  parameter bit INIT_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic sync_out,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int             CW       = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
      stable <= INIT_LEVEL;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      rise   <= 1'b0;
      fall   <= 1'b0;
      // Any sample matching the stable value restarts the count.
      if (sync_out == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_out;
        cnt    <= '0;
        rise   <= sync_out;
        fall   <= ~sync_out;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/soc_system_debounced_pio.sv
// Avalon-MM debounced input PIO: per-channel debouncers, edge capture with
// write-1-to-clear, interrupt mask and registered level IRQ.
module soc_system_debounced_pio
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DEBOUNCE    = 50000,
  parameter int SYNC_STAGES = 2,
  parameter bit INIT_LEVEL  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] raw_w, stable_w, rise_w, fall_w;
  logic [WIDTH-1:0] irq_mask, edge_capture, rise_en, fall_en;
  logic [WIDTH-1:0] edge_event, wdata, pending;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    soc_system_pio_debounce #(
      .DEBOUNCE    (DEBOUNCE),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT_LEVEL  (INIT_LEVEL)
    ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .din      (in_port[i]),
      .sync_out (raw_w[i]),
      .stable   (stable_w[i]),
      .rise     (rise_w[i]),
      .fall     (fall_w[i])
    );
  end

  // Bus handshake: a write is a single-cycle strobe (chipselect && !write_n)
  // with no wait states; readdata is the address-selected register one clock later.
  assign wr_en        = chipselect && !write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = &{1'b0, writedata};
  assign edge_event   = (rise_w & rise_en) | (fall_w & fall_en);
  assign pending      = edge_capture & irq_mask;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:         rd_mux = 32'(stable_w);
      ADDR_RAW:          rd_mux = 32'(raw_w);
      ADDR_IRQ_MASK:     rd_mux = 32'(irq_mask);
      ADDR_EDGE_CAPTURE: rd_mux = 32'(edge_capture);
      ADDR_RISE_EN:      rd_mux = 32'(rise_en);
      ADDR_FALL_EN:      rd_mux = 32'(fall_en);
      ADDR_PENDING:      rd_mux = 32'(pending);
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata     <= '0;
      irq          <= 1'b0;
      irq_mask     <= '0;
      edge_capture <= '0;
      rise_en      <= '1;
      fall_en      <= '0;
    end else begin
      readdata <= rd_mux;
      irq      <= |pending;
      if (wr_en && address == ADDR_IRQ_MASK) irq_mask <= wdata;
      if (wr_en && address == ADDR_RISE_EN)  rise_en  <= wdata;
      if (wr_en && address == ADDR_FALL_EN)  fall_en  <= wdata;
      // A new event on the same clock as its clear wins, so no edge is lost.
      if (wr_en && address == ADDR_EDGE_CAPTURE)
        edge_capture <= (edge_capture & ~wdata) | edge_event;
      else
        edge_capture <= edge_capture | edge_event;
    end
  end

endmodule

// File: tb/tb_soc_system_debounced_pio.sv
// Directed bench for the debounced PIO with WIDTH=4, DEBOUNCE=4, SYNC_STAGES=2.
module tb_soc_system_debounced_pio;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] rdv;

  soc_system_debounced_pio #(
    .WIDTH       (4),
    .DEBOUNCE    (4),
    .SYNC_STAGES (2),
    .INIT_LEVEL  (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: inputs change and outputs are sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    repeat (3) tick();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;

    // Reset values read back
    bus_rd(3'd0, rdv); check("rst_data", rdv, 32'hF);
    bus_rd(3'd1, rdv); check("rst_raw", rdv, 32'hF);
    bus_rd(3'd4, rdv); check("rst_rise_en", rdv, 32'hF);
    bus_rd(3'd5, rdv); check("rst_fall_en", rdv, 32'h0);
    bus_rd(3'd2, rdv); check("rst_irq_mask", rdv, 32'h0);
    bus_rd(3'd7, rdv); check("addr7_zero", rdv, 32'h0);
    check("rst_irq_low", {31'b0, irq}, 32'h0);

    bus_wr(3'd2, 32'h5);
    bus_rd(3'd2, rdv); check("mask_rw", rdv, 32'h5);
    bus_wr(3'd0, 32'h0);
    bus_rd(3'd0, rdv); check("data_ro", rdv, 32'hF);

    // Falling edge on bit0: stable flips at step+6, visible on readdata at +7
    bus_wr(3'd2, 32'h1);
    bus_wr(3'd5, 32'h1);
    address = 3'd0;
    in_port[0] = 1'b0;
    repeat (6) tick();
    check("fall_data_early", readdata, 32'hF);
    tick();
    check("fall_data_step6", readdata, 32'hE);
    check("fall_irq_early", {31'b0, irq}, 32'h0);
    address = 3'd3;
    tick();
    check("fall_capture", readdata, 32'h1);
    check("fall_irq", {31'b0, irq}, 32'h1);
    repeat (4) tick();
    bus_rd(3'd6, rdv); check("fall_pending", rdv, 32'h1);

    // Clear and check irq drops one clock later
    bus_wr(3'd3, 32'h1);
    check("clr_irq_hold", {31'b0, irq}, 32'h1);
    tick();
    check("clr_irq_drop", {31'b0, irq}, 32'h0);
    bus_rd(3'd3, rdv); check("clr_capture", rdv, 32'h0);

    // Bounce rejection on bit1 with both edges enabled
    bus_wr(3'd5, 32'hF);
    bus_wr(3'd2, 32'hF);
    in_port[1] = 1'b0; repeat (3) tick();
    in_port[1] = 1'b1; repeat (3) tick();
    in_port[1] = 1'b0; repeat (3) tick();
    in_port[1] = 1'b1; repeat (10) tick();
    bus_rd(3'd0, rdv); check("bounce_data", rdv, 32'hE);
    bus_rd(3'd3, rdv); check("bounce_capture", rdv, 32'h0);
    check("bounce_irq", {31'b0, irq}, 32'h0);

    // Rise-only filter on bit1
    bus_wr(3'd5, 32'h0);
    bus_wr(3'd4, 32'h2);
    in_port[1] = 1'b0; repeat (10) tick();
    bus_rd(3'd0, rdv); check("rise_low_data", rdv, 32'hC);
    bus_rd(3'd3, rdv); check("rise_fall_ignored", rdv, 32'h0);
    check("rise_fall_irq", {31'b0, irq}, 32'h0);
    in_port[1] = 1'b1; repeat (10) tick();
    bus_rd(3'd0, rdv); check("rise_high_data", rdv, 32'hE);
    bus_rd(3'd3, rdv); check("rise_capture", rdv, 32'h2);
    check("rise_irq", {31'b0, irq}, 32'h1);
    bus_wr(3'd4, 32'h0);
    bus_rd(3'd3, rdv); check("rise_en_keeps_capture", rdv, 32'h2);
    bus_wr(3'd3, 32'h2);
    tick();
    check("rise_irq_clear", {31'b0, irq}, 32'h0);

    // W1C collision: clear strobe lands on the clock the bit0 event is captured
    bus_wr(3'd4, 32'h1);
    in_port[0] = 1'b1;
    repeat (6) tick();
    bus_wr(3'd3, 32'h1);
    bus_rd(3'd3, rdv); check("collide_set_wins", rdv, 32'h1);
    check("collide_irq", {31'b0, irq}, 32'h1);
    bus_wr(3'd3, 32'h1);
    check("collide_irq_hold", {31'b0, irq}, 32'h1);
    tick();
    check("collide_irq_drop", {31'b0, irq}, 32'h0);
    bus_rd(3'd3, rdv); check("collide_cleared", rdv, 32'h0);

    // Reset in the middle of a bit2 debounce
    bus_wr(3'd5, 32'hF);
    in_port[2] = 1'b0;
    repeat (2) tick();
    reset_n = 1'b0;
    tick();
    check("midrst_irq", {31'b0, irq}, 32'h0);
    in_port[2] = 1'b1;
    tick();
    reset_n = 1'b1;
    bus_rd(3'd0, rdv); check("midrst_data_now", rdv, 32'hF);
    repeat (10) tick();
    bus_rd(3'd0, rdv); check("midrst_data", rdv, 32'hF);
    bus_rd(3'd3, rdv); check("midrst_capture", rdv, 32'h0);
    bus_rd(3'd5, rdv); check("midrst_fall_en", rdv, 32'h0);
    check("midrst_irq_after", {31'b0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
